// File: rtl/mts_seq_pkg.sv
// Shared constants for the MTS sync sequencer: state encodings, error codes,
// GPIO_OUT command bit positions and sysStatusReg field offsets.
package mts_seq_pkg;

  typedef logic [2:0] seqState_t;

  localparam seqState_t ST_IDLE      = 3'd0;
  localparam seqState_t ST_CLEAR     = 3'd1;
  localparam seqState_t ST_QUALIFY   = 3'd2;
  localparam seqState_t ST_REQUEST   = 3'd3;
  localparam seqState_t ST_WAIT_DONE = 3'd4;
  localparam seqState_t ST_LOCKED    = 3'd5;
  localparam seqState_t ST_FAILED    = 3'd6;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_QUAL_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_MTS_TIMEOUT  = 3'd2;
  localparam logic [2:0] ERR_MTS_ERROR    = 3'd3;
  localparam logic [2:0] ERR_LOCK_LOST    = 3'd4;

  localparam int GPIO_START_BIT = 31;
  localparam int GPIO_ABORT_BIT = 30;
  localparam int GPIO_RETRY_LSB = 8;
  localparam int GPIO_QUAL_LSB  = 0;

  localparam int STAT_BUSY_BIT   = 31;
  localparam int STAT_LOCKED_BIT = 30;
  localparam int STAT_FAILED_BIT = 29;
  localparam int STAT_STATE_LSB  = 26;
  localparam int STAT_ERR_LSB    = 23;
  localparam int STAT_RETRY_LSB  = 19;
  localparam int STAT_PROG_LSB   = 11;

  function automatic logic isBusy(input seqState_t s);
    return (s >= ST_CLEAR) && (s <= ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/mts_seq_timeout.sv
// Loadable down-counter used for qualify, MTS-completion and lock-watchdog
// timing; `expired` is high on the armed cycle the count reads 1.
module mts_seq_timeout #(
  parameter int               WIDTH      = 24,
  parameter logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(1)
) (
  input  logic sysClk,
  input  logic sysRst_n,
  input  logic load,
  input  logic arm,
  output logic expired
);

  logic [WIDTH-1:0] count;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (arm && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // A reload in the same cycle takes precedence over expiry.
  assign expired = arm && !load && (count == WIDTH'(1));

endmodule

// File: rtl/mts_sync_sequencer.sv
// RFSoC MTS sequencer: clear SYSREF faults, qualify SYSREF, request MTS and
// supervise completion with retry. Optional lock watchdog: MTS_SEQ_WATCHDOG_EN.
module mts_sync_sequencer
  import mts_seq_pkg::*;
#(
  parameter int                       QUAL_WIDTH     = 8,
  parameter int                       TIMEOUT_WIDTH  = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = TIMEOUT_WIDTH'(10_000_000),
  parameter int                       RETRY_WIDTH    = 4
) (
  input  logic        sysClk,
  input  logic        sysRst_n,
  input  logic        sysCsrStrobe,
  input  logic [31:0] GPIO_OUT,
  output logic [31:0] sysStatusReg,
  input  logic        sysrefEvent,
  input  logic        adcFault,
  input  logic        refFault,
  output logic        faultClear,
  output logic        mtsStart,
  input  logic        mtsDone,
  input  logic        mtsError
);

  seqState_t              state, nextState;
  logic                   clearCnt;
  logic                   qualFresh;
  logic [QUAL_WIDTH-1:0]  progress, qualTarget, progressInc;
  logic [RETRY_WIDTH-1:0] retryCnt, maxRetries;
  logic [2:0]             errCode, errValue;
  logic                   errEvent, retryNow, lockLost;
  logic                   tmoLoad, tmoArm, tmoExpired;
  logic [31:0]            statusNext;

  logic cmdAbort, cmdStart, startOk, anyFault;
  logic unusedGpioBits;

  assign cmdAbort = sysCsrStrobe && GPIO_OUT[GPIO_ABORT_BIT];
  assign cmdStart = sysCsrStrobe && GPIO_OUT[GPIO_START_BIT] && !GPIO_OUT[GPIO_ABORT_BIT];
  assign startOk  = cmdStart && ((state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_FAILED));
  assign anyFault = adcFault || refFault;
  assign progressInc = progress + QUAL_WIDTH'(1);
  assign unusedGpioBits = ^GPIO_OUT[29:12];

`ifdef MTS_SEQ_WATCHDOG_EN
  assign tmoArm = (state == ST_QUALIFY) || (state == ST_WAIT_DONE) || (state == ST_LOCKED);
`else
  assign tmoArm = (state == ST_QUALIFY) || (state == ST_WAIT_DONE);
`endif

  mts_seq_timeout #(
    .WIDTH      (TIMEOUT_WIDTH),
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_timeout (
    .sysClk   (sysClk),
    .sysRst_n (sysRst_n),
    .load     (tmoLoad),
    .arm      (tmoArm),
    .expired  (tmoExpired)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    tmoLoad   = 1'b0;
    errEvent  = 1'b0;
    errValue  = ERR_NONE;
    lockLost  = 1'b0;
    retryNow  = 1'b0;

    case (state)
      ST_CLEAR: begin
        if (clearCnt) begin
          nextState = ST_QUALIFY;
          tmoLoad   = qualFresh;
        end
      end
      ST_QUALIFY: begin
        if (anyFault) begin
          nextState = ST_CLEAR;
        end else if (tmoExpired) begin
          errEvent = 1'b1;
          errValue = ERR_QUAL_TIMEOUT;
        end else if (sysrefEvent && (progressInc == qualTarget)) begin
          nextState = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        nextState = ST_WAIT_DONE;
        tmoLoad   = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (mtsError) begin
          errEvent = 1'b1;
          errValue = ERR_MTS_ERROR;
        end else if (mtsDone) begin
          nextState = ST_LOCKED;
`ifdef MTS_SEQ_WATCHDOG_EN
          tmoLoad   = 1'b1;
`endif
        end else if (tmoExpired) begin
          errEvent = 1'b1;
          errValue = ERR_MTS_TIMEOUT;
        end
      end
      ST_LOCKED: begin
`ifdef MTS_SEQ_WATCHDOG_EN
        if (anyFault || tmoExpired) begin
          nextState = ST_FAILED;
          lockLost  = 1'b1;
        end else begin
          tmoLoad = sysrefEvent;
        end
`endif
      end
      default: ;
    endcase

    if (errEvent) begin
      retryNow  = (retryCnt < maxRetries);
      nextState = retryNow ? ST_CLEAR : ST_FAILED;
    end
    if (startOk) nextState = ST_CLEAR;
    if (cmdAbort) nextState = ST_IDLE;
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state      <= ST_IDLE;
      clearCnt   <= 1'b0;
      qualFresh  <= 1'b0;
      progress   <= '0;
      qualTarget <= '0;
      retryCnt   <= '0;
      maxRetries <= '0;
      errCode    <= ERR_NONE;
      faultClear <= 1'b0;
      mtsStart   <= 1'b0;
    end else begin
      state      <= nextState;
      clearCnt   <= (state == ST_CLEAR) && (nextState == ST_CLEAR);
      faultClear <= (nextState == ST_CLEAR) && (state != ST_CLEAR);
      mtsStart   <= (nextState == ST_REQUEST) || (nextState == ST_WAIT_DONE);

      if (!cmdAbort) begin
        if (startOk) begin
          qualTarget <= (GPIO_OUT[GPIO_QUAL_LSB +: QUAL_WIDTH] == '0) ? QUAL_WIDTH'(1)
                                                                     : GPIO_OUT[GPIO_QUAL_LSB +: QUAL_WIDTH];
          maxRetries <= GPIO_OUT[GPIO_RETRY_LSB +: RETRY_WIDTH];
          retryCnt   <= '0;
          errCode    <= ERR_NONE;
          qualFresh  <= 1'b1;
        end else begin
          if (errEvent) errCode <= errValue;
          if (lockLost) errCode <= ERR_LOCK_LOST;
          if (retryNow) begin
            retryCnt  <= retryCnt + RETRY_WIDTH'(1);
            qualFresh <= 1'b1;
          end
          if ((state == ST_CLEAR) && clearCnt) begin
            progress <= '0;
          end else if (state == ST_QUALIFY) begin
            // A fault re-clear keeps the running qualify timeout instead of reloading it.
            if (anyFault) begin
              progress  <= '0;
              qualFresh <= 1'b0;
            end else if (sysrefEvent && !tmoExpired) begin
              progress <= progressInc;
            end
          end
        end
      end
    end
  end

  always_comb begin
    statusNext                                   = '0;
    statusNext[STAT_BUSY_BIT]                    = isBusy(state);
    statusNext[STAT_LOCKED_BIT]                  = (state == ST_LOCKED);
    statusNext[STAT_FAILED_BIT]                  = (state == ST_FAILED);
    statusNext[STAT_STATE_LSB +: 3]              = state;
    statusNext[STAT_ERR_LSB +: 3]                = errCode;
    statusNext[STAT_RETRY_LSB +: RETRY_WIDTH]    = retryCnt;
    statusNext[STAT_PROG_LSB +: QUAL_WIDTH]      = progress;
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) sysStatusReg <= '0;
    else           sysStatusReg <= statusNext;
  end

endmodule

// File: tb/tb_mts_sync_sequencer.sv
// Directed self-checking bench for mts_sync_sequencer (timeout shortened to 100).
module tb_mts_sync_sequencer;

  logic        sysClk = 1'b0;
  logic        sysRst_n = 1'b0;
  logic        sysCsrStrobe = 1'b0;
  logic [31:0] GPIO_OUT = '0;
  logic [31:0] sysStatusReg;
  logic        sysrefEvent = 1'b0;
  logic        adcFault = 1'b0;
  logic        refFault = 1'b0;
  logic        faultClear;
  logic        mtsStart;
  logic        mtsDone = 1'b0;
  logic        mtsError = 1'b0;

  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] PROG_MASK = 32'h0007_F800;
  localparam logic [31:0] KEEP_MASK = ~PROG_MASK;

  mts_sync_sequencer #(
    .QUAL_WIDTH     (8),
    .TIMEOUT_WIDTH  (24),
    .TIMEOUT_CYCLES (24'd100),
    .RETRY_WIDTH    (4)
  ) dut (
    .sysClk       (sysClk),
    .sysRst_n     (sysRst_n),
    .sysCsrStrobe (sysCsrStrobe),
    .GPIO_OUT     (GPIO_OUT),
    .sysStatusReg (sysStatusReg),
    .sysrefEvent  (sysrefEvent),
    .adcFault     (adcFault),
    .refFault     (refFault),
    .faultClear   (faultClear),
    .mtsStart     (mtsStart),
    .mtsDone      (mtsDone),
    .mtsError     (mtsError)
  );

  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic csrWrite(input logic [31:0] word);
    sysCsrStrobe = 1'b1;
    GPIO_OUT     = word;
    tick();
    sysCsrStrobe = 1'b0;
    GPIO_OUT     = '0;
  endtask

  // Each event is followed by one quiet cycle.
  task automatic qualEvents(input int n);
    for (int i = 0; i < n; i++) begin
      sysrefEvent = 1'b1;
      tick();
      sysrefEvent = 1'b0;
      tick();
    end
  endtask

  function automatic logic [31:0] expStatus(input int s, input int e, input int r, input int p);
    logic [31:0] w;
    logic [2:0]  s3, e3;
    logic [3:0]  r4;
    logic [7:0]  p8;
    s3 = s[2:0];
    e3 = e[2:0];
    r4 = r[3:0];
    p8 = p[7:0];
    w = '0;
    w[31]    = (s >= 1) && (s <= 4);
    w[30]    = (s == 5);
    w[29]    = (s == 6);
    w[28:26] = s3;
    w[25:23] = e3;
    w[22:19] = r4;
    w[18:11] = p8;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    ticks(2);
    check("reset_status", sysStatusReg, 32'h0);
    check("reset_mtsStart", {31'd0, mtsStart}, 32'd0);
    check("reset_faultClear", {31'd0, faultClear}, 32'd0);
    sysRst_n = 1'b1;
    ticks(2);
    check("idle_status", sysStatusReg, 32'h0);

    // Qualify (4 events) and lock, mtsDone 10 cycles after mtsStart.
    csrWrite(32'h8000_0204);
    check("t1_faultClear_first", {31'd0, faultClear}, 32'd1);
    tick();
    check("t1_faultClear_second", {31'd0, faultClear}, 32'd0);
    check("t1_status_clear", sysStatusReg, expStatus(1, 0, 0, 0));
    tick();
    qualEvents(3);
    check("t1_no_early_start", {31'd0, mtsStart}, 32'd0);
    sysrefEvent = 1'b1;
    tick();
    sysrefEvent = 1'b0;
    check("t1_mtsStart_request", {31'd0, mtsStart}, 32'd1);
    check("t1_status_progress3", sysStatusReg, expStatus(2, 0, 0, 3));
    ticks(9);
    check("t1_mtsStart_held", {31'd0, mtsStart}, 32'd1);
    mtsDone = 1'b1;
    tick();
    mtsDone = 1'b0;
    check("t1_mtsStart_falls", {31'd0, mtsStart}, 32'd0);
    tick();
    check("t1_status_locked", sysStatusReg, expStatus(5, 0, 0, 4));

    // Fault during qualify forces a second clear and requalification.
    csrWrite(32'h8000_0204);
    ticks(2);
    qualEvents(2);
    refFault = 1'b1;
    tick();
    refFault = 1'b0;
    check("t2_faultClear_again", {31'd0, faultClear}, 32'd1);
    tick();
    check("t2_status_progress0", sysStatusReg, expStatus(1, 0, 0, 0));
    tick();
    qualEvents(4);
    check("t2_mtsStart_wait", {31'd0, mtsStart}, 32'd1);
    mtsDone = 1'b1;
    tick();
    mtsDone = 1'b0;
    tick();
    check("t2_status_locked", sysStatusReg, expStatus(5, 0, 0, 4));

    // Retry exhaustion: maxRetries=1, two mtsError pulses.
    csrWrite(32'h8000_0101);
    ticks(2);
    qualEvents(1);
    mtsError = 1'b1;
    tick();
    mtsError = 1'b0;
    check("t3_retry_mtsStart_low", {31'd0, mtsStart}, 32'd0);
    check("t3_retry_faultClear", {31'd0, faultClear}, 32'd1);
    ticks(2);
    qualEvents(1);
    mtsError = 1'b1;
    tick();
    mtsError = 1'b0;
    check("t3_failed_mtsStart_low", {31'd0, mtsStart}, 32'd0);
    tick();
    check("t3_status_failed", sysStatusReg & KEEP_MASK, expStatus(6, 3, 1, 0));

    // MTS timeout: expiry exactly 100 cycles after REQUEST.
    csrWrite(32'h8000_0101);
    ticks(2);
    qualEvents(1);
    ticks(99);
    check("t4_mtsStart_before_expiry", {31'd0, mtsStart}, 32'd1);
    tick();
    check("t4_mtsStart_after_expiry", {31'd0, mtsStart}, 32'd0);
    check("t4_retry_faultClear", {31'd0, faultClear}, 32'd1);
    tick();
    check("t4_status_timeout", sysStatusReg & KEEP_MASK, expStatus(1, 2, 1, 0));

    // Start during WAIT_DONE is ignored; done+error together take the error path.
    tick();
    qualEvents(1);
    csrWrite(32'h8000_0509);
    check("t5_ignored_faultClear", {31'd0, faultClear}, 32'd0);
    check("t5_ignored_mtsStart", {31'd0, mtsStart}, 32'd1);
    tick();
    check("t5_ignored_status", sysStatusReg & KEEP_MASK, expStatus(4, 2, 1, 0));
    mtsDone  = 1'b1;
    mtsError = 1'b1;
    tick();
    mtsDone  = 1'b0;
    mtsError = 1'b0;
    check("t5_collide_mtsStart", {31'd0, mtsStart}, 32'd0);
    tick();
    check("t5_collide_status", sysStatusReg & KEEP_MASK, expStatus(6, 3, 1, 0));

    // Start and abort in one write: abort wins.
    csrWrite(32'hC000_0101);
    check("t5_startabort_faultClear", {31'd0, faultClear}, 32'd0);
    tick();
    check("t5_startabort_idle", {26'd0, sysStatusReg[31:26]}, 32'd0);

    // Abort mid-qualify returns to IDLE.
    csrWrite(32'h8000_0004);
    ticks(2);
    qualEvents(1);
    csrWrite(32'h4000_0000);
    tick();
    check("t5_abort_idle", {26'd0, sysStatusReg[31:26]}, 32'd0);
    check("t5_abort_mtsStart", {31'd0, mtsStart}, 32'd0);

    // qualCount 0 acts as 1; maxRetries 0 fails on the first error.
    csrWrite(32'h8000_0000);
    ticks(2);
    qualEvents(1);
    check("t6_qual0_mtsStart", {31'd0, mtsStart}, 32'd1);
    mtsError = 1'b1;
    tick();
    mtsError = 1'b0;
    tick();
    check("t6_noretry_failed", sysStatusReg & KEEP_MASK, expStatus(6, 3, 0, 0));

    // Lock watchdog: one event reloads, then silence.
    csrWrite(32'h8000_0000);
    ticks(2);
    qualEvents(1);
    mtsDone = 1'b1;
    tick();
    mtsDone = 1'b0;
    ticks(44);
    sysrefEvent = 1'b1;
    tick();
    sysrefEvent = 1'b0;
    ticks(100);
    check("t7_locked_before_expiry", sysStatusReg & KEEP_MASK, expStatus(5, 0, 0, 0));
    tick();
`ifdef MTS_SEQ_WATCHDOG_EN
    check("t7_watchdog_failed", sysStatusReg & KEEP_MASK, expStatus(6, 4, 0, 0));
`else
    check("t7_stays_locked", sysStatusReg & KEEP_MASK, expStatus(5, 0, 0, 0));
`endif

    // Asynchronous reset mid-request drops mtsStart at once, no restart.
    csrWrite(32'h8000_0001);
    ticks(2);
    qualEvents(1);
    check("t8_mtsStart_before_reset", {31'd0, mtsStart}, 32'd1);
    sysRst_n = 1'b0;
    #2;
    check("t8_mtsStart_async_drop", {31'd0, mtsStart}, 32'd0);
    check("t8_status_async_zero", sysStatusReg, 32'h0);
    tick();
    sysRst_n = 1'b1;
    ticks(5);
    check("t8_no_restart_status", sysStatusReg, 32'h0);
    check("t8_no_restart_mtsStart", {31'd0, mtsStart}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mts_sync_sequencer.md
# mts_sync_sequencer

Sequences RFSoC multi-tile synchronization (MTS) in the `sysClk` domain. It clears the SYSREF period checker's sticky faults and qualifies SYSREF over a programmable run of consecutive fault-free events. It then issues an MTS start request to the converter-side sync logic and supervises completion with timeout and bounded retry. It sits between the CSR/GPIO register bank and the SYSREF checker / RF data converter MTS control.

## Interface
- `QUAL_WIDTH`, 8: width of the qualify-event counter.
- `TIMEOUT_WIDTH`, 24: width of the timeout counter, in `sysClk` cycles.
- `TIMEOUT_CYCLES`, 24'd10_000_000: load value for every timeout.
- `RETRY_WIDTH`, 4: width of the retry counter.

Ports:
- `sysClk`  in  1  system clock.
- `sysRst_n`  in  1  asynchronous, active-low reset.
- `sysCsrStrobe`  in  1  one-cycle write strobe for `GPIO_OUT`.
- `GPIO_OUT`  in  32  command word:
  - [31] start.
  - [30] abort.
  - [11:8] maxRetries.
  - [7:0] qualCount.
- `sysStatusReg`  out  32  status word, layout under Operation.
- `sysrefEvent`  in  1  one-cycle pulse per SYSREF rising edge, already in `sysClk` domain.
- `adcFault`, `refFault`  in  1 each  sticky period faults from the checker.
- `faultClear`  out  1  one-cycle pulse clearing checker faults.
- `mtsStart`  out  1  level request to MTS logic.
- `mtsDone`  in  1  MTS completion pulse.
- `mtsError`  in  1  MTS failure pulse.

## Operation
States: IDLE, CLEAR, QUALIFY, REQUEST, WAIT_DONE, LOCKED, FAILED.

- **Command capture.** Start is accepted only in IDLE, LOCKED or FAILED. On acceptance, latch qualCount and maxRetries, zero the retry counter and error code, then go to CLEAR.
  - qualCount 0 is treated as 1.
  - Abort in any state goes to IDLE; abort wins over start in the same write.
- **CLEAR**, 2 cycles: `faultClear` pulses in the first cycle; the second cycle lets the checker settle. Then go to QUALIFY with progress = 0 and the timeout loaded.
- **QUALIFY:**
  - Each `sysrefEvent` with both faults low increments progress.
  - Any fault high resets progress to 0 and returns to CLEAR. This does not consume a retry and does not reload the timeout.
  - Fault and event in the same cycle: fault wins.
  - Progress reaching qualCount goes to REQUEST.
- **REQUEST**, 1 cycle: assert `mtsStart`, load the timeout, go to WAIT_DONE.
- **WAIT_DONE:**
  - `mtsStart` is held high.
  - `mtsDone` goes to LOCKED.
  - `mtsError` or timeout expiry records an error and counts a retry.
  - Priority in the same cycle: error > done > timeout.
- **Retry rule.** If retries used < maxRetries, increment and go to CLEAR; otherwise go to FAILED. maxRetries 0 means no retry.
- **Qualify timeout:** expiry in QUALIFY follows the same retry rule, with error code 1.
- **Error codes:** 0 none, 1 qualify timeout, 2 MTS timeout, 3 MTS error, 4 lock lost.
- **Status word** (all other bits 0):
  - [31] busy (CLEAR..WAIT_DONE).
  - [30] locked.
  - [29] failed.
  - [28:26] state encoding: IDLE=0, CLEAR=1, QUALIFY=2, REQUEST=3, WAIT_DONE=4, LOCKED=5, FAILED=6.
  - [25:23] error code.
  - [22:19] retries used.
  - [18:11] qualify progress.

## Timing
- Reset values:
  - state IDLE.
  - `faultClear` 0, `mtsStart` 0.
  - `sysStatusReg` 0.
  - All counters 0.
- Start-accepting write at cycle N: CLEAR entered at N+1, `faultClear` high at N+1 only.
- The earliest `mtsStart` comes 1 cycle after the qualifying event; it falls the cycle after done, error or timeout.
- The timeout decrements every cycle while armed. It expires on the cycle it reads 1, i.e. exactly TIMEOUT_CYCLES cycles after load.
- `sysStatusReg` is registered and lags the state by 1 cycle.
- Asynchronous reset mid-sequence drops `mtsStart` immediately. The block does not auto-restart.

## Configuration
- `MTS_SEQ_WATCHDOG_EN` defined: in LOCKED the timeout reloads on each `sysrefEvent`. Timeout expiry, or any fault, goes to FAILED with error 4; no retry.
- Macro undefined: LOCKED is held until start or abort, and faults are ignored in LOCKED.

## Structure
- Package `mts_seq_pkg` holds:
  - The state enum.
  - Error-code constants.
  - The `GPIO_OUT` bit positions.
  - The status-field offsets.
- One sub-module, `mts_seq_timeout`: loadable down-counter with arm, load and `expired` pulse. It is used for qualify, MTS and watchdog timing.

## Test plan
- **Qualify and lock:** qualCount=4, maxRetries=2, 4 clean events, then `mtsDone` 10 cycles after `mtsStart` → LOCKED; status[30]=1, error 0, retries 0.
- **Fault during qualify:** `refFault` high after event 2 → second `faultClear` pulse, progress 0, then requalify with 4 events → lock; retries still 0.
- **Retry exhaustion:** maxRetries=1, `mtsError` twice → FAILED, error 3, retries 1, `mtsStart` low.
- **MTS timeout:** TIMEOUT_CYCLES=100, no `mtsDone` → expiry exactly 100 cycles after REQUEST, then retry; status error 2.
- **Command collisions:** start+abort in one write → IDLE. Start while in WAIT_DONE → ignored. `mtsDone` and `mtsError` in one cycle → error path.
- **Watchdog (macro defined):** in LOCKED, stop `sysrefEvent` → FAILED with error 4 after TIMEOUT_CYCLES. With the macro undefined, the block stays LOCKED.
